// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Round-robin scheduler that shares one UART transmitter among N_REQ byte
// producers. One byte is accepted per frame through a valid/ready handshake,
// handed to the transmitter as a one-cycle tx_valid pulse, and further grants
// are held off until the transmitter has had time to return to idle.
//
// Ports
//   CLK          clock, all logic on the rising edge
//   RESET        synchronous active-low reset
//   req_valid    per-requester byte available
//   req_data     requester i byte at [8*i+7:8*i]
//   req_ready    one-hot accept strobe (combinational, IDLE only)
//   tx_data      registered byte to the transmitter
//   tx_valid     registered one-cycle start pulse
//   busy         high while a frame is being issued or waited out
//   grant_id     index of the last granted requester
//   frames_sent  wrapping count of issued frames
//
// state   | meaning
// S_IDLE  | arbitrate; accept one byte if any requester is valid
// S_ISSUE | tx_valid high for one cycle, load frame wait counter
// S_WAIT  | hold off grants until the transmitter is idle again

module uart_tx_sched #(
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = 10,
  parameter int CNT_W        = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic [CNT_W-1:0]     frames_sent
);

  localparam int WAIT_W = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic              sel_found;
  logic [2:0]        sel_idx;
  logic [7:0]        sel_byte;

  // Round-robin pick: first valid requester at offset 1..N_REQ from the last
  // grant. Constant indices only, so every select unrolls to a fixed mux.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_byte  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!sel_found && req_valid[i] &&
            (i == ((int'(grant_id) + k) % N_REQ))) begin
          sel_found = 1'b1;
          sel_idx   = 3'(i);
        end
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_idx == 3'(i)) sel_byte = req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    case (state)
      S_IDLE: begin
        if (sel_found) begin
          state_nx = S_ISSUE;
          for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = (sel_idx == 3'(i));
          end
        end
      end
      S_ISSUE: state_nx = S_WAIT;
      // Leave on the edge where the decremented count reaches zero, giving
      // FRAME_CYCLES-1 wait cycles and an 11-cycle pulse spacing at default.
      S_WAIT: if (wait_cnt <= WAIT_W'(1)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= S_IDLE;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= 3'(N_REQ - 1);
      frames_sent <= '0;
      wait_cnt    <= '0;
    end else begin
      state    <= state_nx;
      tx_valid <= (state == S_IDLE) && sel_found;
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            tx_data  <= sel_byte;
            grant_id <= sel_idx;
          end
        end
        S_ISSUE: begin
          frames_sent <= frames_sent + 1'b1;
          wait_cnt    <= WAIT_W'(FRAME_CYCLES - 1);
        end
        S_WAIT: wait_cnt <= wait_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: directed steps, scoreboard of expected bytes,
// a small serial transmitter model, and a second instance with a 4-bit
// frame counter sharing the same inputs for the wrap check.

module tb_uart_tx_sched;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;

  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           busy;
  logic [2:0]     grant_id;
  logic [15:0]    frames_sent;

  logic [N-1:0]   ready_w;
  logic [7:0]     tx_data_w;
  logic           tx_valid_w;
  logic           busy_w;
  logic [2:0]     grant_w;
  logic [3:0]     frames_w;

  uart_tx_sched dut (
    .CLK(clk), .RESET(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .busy(busy), .grant_id(grant_id), .frames_sent(frames_sent)
  );

  uart_tx_sched #(.CNT_W(4)) dut_w (
    .CLK(clk), .RESET(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready_w), .tx_data(tx_data_w), .tx_valid(tx_valid_w),
    .busy(busy_w), .grant_id(grant_w), .frames_sent(frames_w)
  );

  always #5 clk = ~clk;

  // Transmitter model: start, 8 data bits LSB first, stop; one bit per clock.
  logic [9:0] tx_sh;
  logic [3:0] tx_cnt;
  logic       ser_line;

  always @(posedge clk) begin
    if (!reset) begin
      tx_cnt <= '0;
      tx_sh  <= '1;
    end else if (tx_valid) begin
      tx_sh  <= {1'b1, tx_data, 1'b0};
      tx_cnt <= 4'd10;
    end else if (tx_cnt != 0) begin
      tx_sh  <= {1'b1, tx_sh[9:1]};
      tx_cnt <= tx_cnt - 4'd1;
    end
  end

  assign ser_line = (tx_cnt != 0) ? tx_sh[0] : 1'b1;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and check the handshake invariants.
  task automatic step();
    @(negedge clk);
    #1;
    check("ready_outside_idle", req_ready & {N{busy}}, 0);
    check("ready_without_valid", req_ready & ~req_valid, 0);
  endtask

  task automatic wait_tx(input string tag, output int lat);
    logic [7:0] exp;
    lat = 0;
    do begin
      step();
      lat++;
    end while (tx_valid !== 1'b1 && lat < 40);
    if (tx_valid !== 1'b1) begin
      check({tag, "_timeout"}, tx_valid, 1);
    end else if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, sb.size(), 1);
    end else begin
      exp = sb.pop_front();
      check({tag, "_data"}, tx_data, exp);
      check({tag, "_data_w"}, tx_data_w, exp);
      check({tag, "_txv_w"}, tx_valid_w, 1);
      check({tag, "_tx_idle"}, tx_cnt, 0);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 30) begin
      step();
      n++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int lat;
    int k;
    logic [11:0] ln;
    logic [11:0] bz;
    logic [7:0]  dec;

    // Reset held for three edges
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 3);
    check("rst_frames", frames_sent, 0);
    check("rst_ready", req_ready, 0);
    check("rst_tx_data", tx_data, 0);
    reset = 1'b1;
    repeat (5) begin
      step();
      check("idle_ready", req_ready, 0);
      check("idle_tx_valid", tx_valid, 0);
    end

    // Single request from requester 0
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    #1;
    check("single_ready", req_ready, 4'b0001);
    sb.push_back(8'hA5);
    wait_tx("single", lat);
    check("single_latency", lat, 1);
    req_valid = '0;
    for (int i = 0; i < 12; i++) begin
      ln[i] = ser_line;
      bz[i] = busy;
      step();
    end
    check("single_busy_cycles", $countones(bz), 10);
    for (int j = 0; j < 8; j++) dec[j] = ln[2+j];
    check("serial_start", ln[1], 0);
    check("serial_byte", dec, 8'hA5);
    check("serial_stop", ln[10], 1);
    check("single_frames", frames_sent, 1);

    // Round robin with all requesters continuously valid
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rr_reset_grant", grant_id, 3);
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'hF;
    #1;
    check("rr_first_ready", req_ready, 4'b0001);
    sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33);
    sb.push_back(8'h44); sb.push_back(8'h11);
    for (int r = 0; r < 5; r++) begin
      wait_tx("rr", lat);
      check("rr_spacing", lat, (r == 0) ? 1 : 11);
      check("rr_grant", grant_id, r % 4);
    end
    req_valid = '0;
    wait_idle("rr");
    check("rr_frames", frames_sent, 5);

    // Requester 2 arrives during the wait of a requester-1 frame
    req_data[15:8] = 8'h5C;
    req_valid = 4'b0010;
    #1;
    check("arr_ready1", req_ready, 4'b0010);
    sb.push_back(8'h5C);
    wait_tx("arr1", lat);
    check("arr1_latency", lat, 1);
    req_valid = '0;
    k = 0;
    repeat (3) begin
      step();
      k++;
    end
    req_data[23:16] = 8'h7E;
    req_valid = 4'b0100;
    #1;
    check("arr_early", req_ready, 0);
    sb.push_back(8'h7E);
    while (busy && k < 30) begin
      step();
      k++;
      if (busy) check("arr_hold", req_ready, 0);
    end
    check("arr_first_idle", k, 10);
    check("arr_ready2", req_ready, 4'b0100);
    wait_tx("arr2", lat);
    check("arr2_latency", lat, 1);
    check("arr2_grant", grant_id, 2);
    req_valid = '0;

    // Reset in wait cycle 4 with requesters 0 and 3 pending
    repeat (4) step();
    reset = 1'b0;
    req_data[7:0]   = 8'h3C;
    req_data[31:24] = 8'h99;
    req_valid = 4'b1001;
    step();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frames", frames_sent, 0);
    check("mid_rst_frames_w", frames_w, 0);
    check("mid_rst_grant", grant_id, 3);
    check("mid_rst_tx_valid", tx_valid, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", req_ready, 4'b0001);
    sb.push_back(8'h3C);
    wait_tx("mid_rst", lat);
    check("mid_rst_latency", lat, 1);
    check("mid_rst_grant0", grant_id, 0);
    req_valid = '0;
    wait_idle("mid_rst");

    // 17 frames: 16-bit counter reads 17, 4-bit counter wraps to 1
    reset = 1'b0;
    step();
    reset = 1'b1;
    req_data[7:0] = 8'h5A;
    req_valid = 4'b0001;
    repeat (17) sb.push_back(8'h5A);
    for (int r = 0; r < 17; r++) begin
      wait_tx("wrap", lat);
      check("wrap_spacing", lat, (r == 0) ? 1 : 11);
    end
    req_valid = '0;
    wait_idle("wrap");
    check("wrap_frames16", frames_sent, 17);
    check("wrap_frames4", frames_w, 1);
    check("wrap_grant_w", grant_w, 0);
    check("wrap_busy_w", busy_w, 0);
    check("wrap_ready_w", ready_w, 0);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler sharing one single-bit-per-clock UART transmitter among N_REQ byte producers.
- Accepts one byte from a requester via a valid/ready handshake, then drives a one-cycle tx_valid pulse with tx_data to the transmitter.
- Holds off further grants for the transmitter's fixed frame length.
- Sits between producer blocks (status, debug, telemetry) and the transmitter's data/valid inputs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FRAME_CYCLES, 10, transmitter cycles from valid sample back to idle: start + 8 data + stop.
- CNT_W, 16, width of the frames_sent counter.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RESET  input  1  synchronous, active-low reset.
- req_valid  input  N_REQ  per-requester byte available.
- req_data  input  8*N_REQ  requester i byte at bits [8*i+7:8*i].
- req_ready  output  N_REQ  one-hot accept strobe; combinational from state and req_valid.
- tx_data  output  8  byte to transmitter; registered.
- tx_valid  output  1  one-cycle start pulse to transmitter; registered.
- busy  output  1  high in ISSUE or WAIT.
- grant_id  output  3  index of last granted requester; registered.
- frames_sent  output  CNT_W  count of issued frames; wraps at 2^CNT_W.

Behaviour:
- Reset (RESET low at a clock edge):
  - state=IDLE, tx_valid=0, tx_data=0, busy=0.
  - grant_id=N_REQ-1, so requester 0 has first priority.
  - frames_sent=0, wait counter=0.
- Mid-frame reset aborts the frame immediately. No further tx_valid until a new grant.
- The transmitter is reset from the same reset source.
- State IDLE:
  - If any req_valid: select the first set bit searching from (grant_id+1) mod N_REQ upward, wrapping.
  - Assert req_ready for that index only, in the same cycle.
  - Latch req_data slice into tx_data; grant_id<=index; go to ISSUE.
  - Else req_ready=0 and remain in IDLE.
- State ISSUE (exactly 1 cycle):
  - tx_valid=1, tx_data stable, frames_sent<=frames_sent+1.
  - Load wait counter with FRAME_CYCLES-1; go to WAIT.
- State WAIT:
  - tx_valid=0, req_ready=0.
  - Decrement counter each cycle; when counter==0 at a clock edge, go to IDLE.
  - WAIT lasts FRAME_CYCLES-1 cycles.
- Timing:
  - Handshake cycle to tx_valid: 1 cycle.
  - Minimum spacing between tx_valid pulses: FRAME_CYCLES+1 cycles (11 at default).
  - The transmitter is always idle when tx_valid asserts.
- Handshake rules:
  - A requester holds req_valid and req_data stable until it sees req_ready.
  - Dropping req_valid before acceptance is legal; that byte is simply not sent.
  - req_ready is never asserted outside IDLE.
  - req_ready is never asserted to a requester whose req_valid is low.
- Fairness:
  - With all requesters continuously valid, grants cycle 0,1,..,N_REQ-1,0.
  - No requester waits more than N_REQ frames.
- Simultaneous events:
  - A requester that raises req_valid in the same cycle as IDLE is considered in that cycle.
  - A request arriving during WAIT is served no earlier than the next IDLE.
- Widths:
  - grant_id index is zero-extended to 3 bits.
  - frames_sent wraps from all-ones to 0 without flagging.
- tx_data holds its last value outside ISSUE.

Test Plan:
- Reset behaviour: hold RESET low 3 cycles, then release with no requests -> tx_valid=0, busy=0, grant_id=3, frames_sent=0, req_ready=0 indefinitely.
- Single request: req_valid=0001, data0=0xA5 -> req_ready=0001 that cycle; next cycle tx_valid=1 with tx_data=0xA5; busy high 10 cycles; frames_sent=1; a serial monitor on the transmitter output decodes 0xA5.
- Round robin: req_valid=1111 held with data 0x11/0x22/0x33/0x44 -> grants 0,1,2,3,0; tx_valid pulses exactly 11 cycles apart.
- Arrival during WAIT: requester 2 asserts during WAIT of a requester-1 frame -> req_ready[2] in the first IDLE cycle after WAIT, never earlier.
- Reset mid-frame: RESET low during WAIT cycle 4 -> next cycle state=IDLE, busy=0, frames_sent=0; a pending request is granted starting from index 0.
- Counter wrap: CNT_W=4, issue 17 frames -> frames_sent reads 1.
